add8_err_meter: RTL and testbench
=================================

# add8_err_meter

Sequential error-characterisation engine for the 8-bit approximate adders in the library. It drives every one of the 65536 operand pairs into an external combinational or pipelined adder under test, one pair per clock. It reads back the 9-bit sum and accumulates exact error statistics against the true sum: total absolute error, worst-case error, and error count. It is the consumer end of the adder interface and produces the figures quoted in each adder's header (MAE, WCE, EP, and optionally MSE) in hardware.

## Interface
- `LAT`, default 0: cycles between a pair appearing on `dut_a`/`dut_b` and its sum being valid on `dut_o`. Use 0 for a purely combinational adder under test.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin a full sweep; sampled only in IDLE or DONE.
- `busy`  out  1  high while the sweep or drain is in progress.
- `done`  out  1  one-cycle pulse when the results are final.
- `dut_a`  out  8  operand A to the adder under test (registered).
- `dut_b`  out  8  operand B to the adder under test (registered).
- `dut_o`  in  9  sum returned by the adder under test.
- `err_sum`  out  25  sum over all pairs of |dut_o − (A+B)|.
- `wce`  out  9  maximum |dut_o − (A+B)| seen.
- `err_cnt`  out  17  number of pairs with a nonzero error.

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- Index counter `idx[15:0]`; `dut_a = idx[15:8]`, `dut_b = idx[7:0]`.
- Transitions:
  - IDLE or DONE with `start`=1 → SWEEP. Clear `idx`, `err_sum`, `wce` and `err_cnt`.
  - SWEEP: increment `idx` every cycle. When `idx`=0xFFFF → DRAIN, or → DONE directly if `LAT`=0.
  - DRAIN: count `LAT` cycles → DONE.
  - DONE: assert `done` for one cycle, then stay in DONE holding results until `start`.
- Reference sum `ref = A+B` (9 bits, exact) passes through a `LAT`-deep delay line with a valid bit, aligned to `dut_o`.
- Per valid sample:
  - `e = |dut_o − ref|`, computed in 10-bit signed arithmetic, magnitude 0..511.
  - `err_sum += e`.
  - `wce = max(wce, e)`.
  - `err_cnt += (e≠0)`.
- Accumulator widths are sized so that no overflow is possible (65536·511 < 2²⁵). No saturation logic is required.
- `start` in SWEEP or DRAIN is ignored.
- `start` asserted on the `done` cycle restarts the sweep and clears the results.
- `rst` at any time, including mid-sweep:
  - next state IDLE;
  - all outputs 0;
  - delay-line valid bits cleared;
  - the partial sweep is discarded.
- Reset values: `busy`=0, `done`=0, `dut_a`=0, `dut_b`=0, `err_sum`=0, `wce`=0, `err_cnt`=0 (and `sq_sum`=0 when compiled in).

## Timing
- `start` high in cycle t → cycle t+1: state SWEEP, `busy`=1, `dut_a`/`dut_b`=0/0.
- Pair i is presented in cycle t+1+i and `dut_o` is sampled in cycle t+1+i+`LAT`. The sample is accumulated at the end of that cycle.
- The last pair (0xFF,0xFF) is presented in cycle t+65536.
- `done`=1 and `busy`=0 in cycle t+65537+`LAT`. Total `busy` cycles: 65536+`LAT`.
- Results are stable and valid from the `done` cycle until the next accepted `start` or `rst`.
- `dut_a`/`dut_b` hold 0xFF/0xFF after the sweep ends.

## Configuration
- Macro: `ADD8_ERR_METER_MSE_EN`.
- Defined: adds output `sq_sum` (out, 34 bits), accumulating e² per sample. It is cleared and reset identically to `err_sum` and has the same timing; MSE = `sq_sum`/65536.
- Undefined: no `sq_sum` port, no multiplier or squarer, and all other behaviour is identical.

## Test plan
- Exact adder as DUT, `LAT`=0, pulse `start` → `done` at t+65537; `err_sum`=0, `wce`=0, `err_cnt`=0; `sq_sum`=0 if the macro is enabled.
- Exact adder with O[0] forced 0 → `err_sum`=32768, `wce`=1, `err_cnt`=32768; `sq_sum`=32768 if enabled.
- DUT output tied to 0 → `err_sum`=16711680, `wce`=510, `err_cnt`=65535.
- Same O[0]-forced DUT behind 2 register stages with `LAT`=2 → identical figures to the unpipelined case; `done` at t+65539, `busy` high for 65538 cycles.
- Assert `rst` at sweep cycle 1000, then `start` again → immediate zero outputs and IDLE after the reset. The new sweep's results equal those of a clean run.
- Pulse `start` during SWEEP → ignored, with no change in the `done` cycle. Pulse `start` on the `done` cycle → the sweep restarts and `err_sum` is cleared on the next cycle.

Source files
------------

// File: rtl/add8_err_meter.sv
// add8_err_meter: drives all 65536 operand pairs into an external 8-bit adder and accumulates exact error statistics.
// Define ADD8_ERR_METER_MSE_EN to add the sq_sum output (sum of squared errors).
module add8_err_meter #(
  parameter int LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  dut_a,
  output logic [7:0]  dut_b,
  input  logic [8:0]  dut_o,
  output logic [24:0] err_sum,
  output logic [8:0]  wce,
  output logic [16:0] err_cnt
`ifdef ADD8_ERR_METER_MSE_EN
  ,
  output logic [33:0] sq_sum
`endif
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  localparam logic [15:0] LAST_DRAIN = 16'(LAT - 1);

  state_t      state;
  logic [15:0] idx;
  logic [15:0] drain_cnt;
  logic        clr;
  logic [8:0]  ref_p0;
  logic        vld_p0;
  logic [8:0]  ref_al;
  logic        vld_al;
  logic [8:0]  err_mag;

  function automatic logic [8:0] abs_err(input logic [8:0] o, input logic [8:0] r);
    logic signed [9:0] d;
    logic signed [9:0] m;
    d = $signed({1'b0, o}) - $signed({1'b0, r});
    m = (d < 0) ? -d : d;
    return m[8:0];
  endfunction

  assign dut_a = idx[15:8];
  assign dut_b = idx[7:0];
  assign clr   = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SWEEP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (idx == 16'hFFFF) begin
            if (LAT == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            idx <= idx + 16'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // stage p0: exact reference sum of the pair currently presented
  assign ref_p0 = {1'b0, dut_a} + {1'b0, dut_b};
  assign vld_p0 = (state == SWEEP);

  generate
    if (LAT == 0) begin : g_comb
      assign ref_al = ref_p0;
      assign vld_al = vld_p0;
    end else begin : g_dly
      // stage p1: LAT-deep delay line aligning the reference with dut_o
      logic [8:0]     ref_p1 [LAT];
      logic [LAT-1:0] vld_p1;

      always_ff @(posedge clk) begin
        ref_p1[0] <= ref_p0;
        for (int k = 1; k < LAT; k++) ref_p1[k] <= ref_p1[k-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p1 <= '0;
        end else begin
          vld_p1[0] <= vld_p0;
          for (int k = 1; k < LAT; k++) vld_p1[k] <= vld_p1[k-1];
        end
      end

      assign ref_al = ref_p1[LAT-1];
      assign vld_al = vld_p1[LAT-1];
    end
  endgenerate

  // stage p2: error magnitude accumulated at the end of the sample cycle
  assign err_mag = abs_err(dut_o, ref_al);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_sum <= '0;
      wce     <= '0;
      err_cnt <= '0;
    end else if (vld_al) begin
      err_sum <= err_sum + 25'(err_mag);
      if (err_mag > wce) wce <= err_mag;
      err_cnt <= err_cnt + 17'(err_mag != 9'd0);
    end
  end

`ifdef ADD8_ERR_METER_MSE_EN
  function automatic logic [17:0] square(input logic [8:0] x);
    return 18'(x) * 18'(x);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sq_sum <= '0;
    end else if (vld_al) begin
      sq_sum <= sq_sum + 34'(square(err_mag));
    end
  end
`endif

endmodule

// File: tb/tb_add8_err_meter.sv
// Bench for add8_err_meter: six meters in parallel against exact, LSB-dropping, zero and random-table adders.
// Builds with or without ADD8_ERR_METER_MSE_EN.
module tb_add8_err_meter;

  logic        clk = 1'b0;
  logic        rst_m, rst_r;
  logic        start_m, start_p, start_z, start_r;
  logic [5:0]  busy_v, done_v;
  logic [7:0]  a_v  [6];
  logic [7:0]  b_v  [6];
  logic [8:0]  o_v  [6];
  logic [24:0] es_v [6];
  logic [8:0]  w_v  [6];
  logic [16:0] c_v  [6];
`ifdef ADD8_ERR_METER_MSE_EN
  logic [33:0] q_v  [6];
`endif

  logic [8:0]  rtab [65536];
  logic [8:0]  p3_1, p3_2, p4_1, p4_2, p4_3;

  int cyc = 0;
  int s_e [6];
  int dn  [6];
  int bc  [6];
  bit arm [6];

  int n_cmp = 0;
  int n_err = 0;

  longint ex_s [4];
  longint ex_w [4];
  longint ex_c [4];
  longint ex_q [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] lsb0(input logic [7:0] a, input logic [7:0] b);
    return ({1'b0, a} + {1'b0, b}) & 9'h1FE;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 3) ? 2 : ((i == 4) ? 3 : 0);
  endfunction

  // 0 exact, 1 LSB forced low, 2 tied to zero, 3 random table
  function automatic int mode_of(input int i);
    case (i)
      0: return 0;
      2: return 2;
      4: return 3;
      default: return 1;
    endcase
  endfunction

  generate
    for (genvar i = 0; i < 6; i++) begin : g_dut
      add8_err_meter #(.LAT(lat_of(i))) u_dut (
        .clk     (clk),
        .rst     ((i == 5) ? rst_r : rst_m),
        .start   ((i == 2) ? start_z : ((i == 5) ? start_r :
                  ((i == 3 || i == 4) ? start_p : start_m))),
        .busy    (busy_v[i]),
        .done    (done_v[i]),
        .dut_a   (a_v[i]),
        .dut_b   (b_v[i]),
        .dut_o   (o_v[i]),
        .err_sum (es_v[i]),
        .wce     (w_v[i]),
        .err_cnt (c_v[i])
`ifdef ADD8_ERR_METER_MSE_EN
        ,
        .sq_sum  (q_v[i])
`endif
      );
    end
  endgenerate

  always_comb begin
    o_v[0] = {1'b0, a_v[0]} + {1'b0, b_v[0]};
    o_v[1] = lsb0(a_v[1], b_v[1]);
    o_v[2] = '0;
    o_v[3] = p3_2;
    o_v[4] = p4_3;
    o_v[5] = lsb0(a_v[5], b_v[5]);
  end

  always @(posedge clk) begin
    p3_1 <= lsb0(a_v[3], b_v[3]);
    p3_2 <= p3_1;
    p4_1 <= rtab[{a_v[4], b_v[4]}];
    p4_2 <= p4_1;
    p4_3 <= p4_2;
  end

  // first done cycle and busy-cycle count, relative to each meter's start edge
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (arm[i] && dn[i] < 0) begin
        if (busy_v[i]) bc[i] <= bc[i] + 1;
        if (done_v[i]) dn[i] <= cyc - s_e[i];
      end
    end
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_stats(input int mode, output longint s, output longint w,
                             output longint c, output longint q);
    s = 0; w = 0; c = 0; q = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        int sum, o, e;
        sum = a + b;
        case (mode)
          0: o = sum;
          1: o = sum - (sum % 2);
          2: o = 0;
          default: o = int'(rtab[a * 256 + b]);
        endcase
        e = (o > sum) ? o - sum : sum - o;
        s += e;
        if (e > w) w = e;
        if (e != 0) c++;
        q += longint'(e) * e;
      end
    end
  endtask

  task automatic check_zero(input int i, input string pfx);
    check_val($sformatf("%s_busy[%0d]", pfx, i), busy_v[i], 0);
    check_val($sformatf("%s_done[%0d]", pfx, i), done_v[i], 0);
    check_val($sformatf("%s_a[%0d]", pfx, i), a_v[i], 0);
    check_val($sformatf("%s_b[%0d]", pfx, i), b_v[i], 0);
    check_val($sformatf("%s_err_sum[%0d]", pfx, i), es_v[i], 0);
    check_val($sformatf("%s_wce[%0d]", pfx, i), w_v[i], 0);
    check_val($sformatf("%s_err_cnt[%0d]", pfx, i), c_v[i], 0);
`ifdef ADD8_ERR_METER_MSE_EN
    check_val($sformatf("%s_sq_sum[%0d]", pfx, i), q_v[i], 0);
`endif
  endtask

  task automatic check_results(input int i);
    int m;
    m = mode_of(i);
    check_val($sformatf("err_sum[%0d]", i), es_v[i], ex_s[m]);
    check_val($sformatf("wce[%0d]", i), w_v[i], ex_w[m]);
    check_val($sformatf("err_cnt[%0d]", i), c_v[i], ex_c[m]);
`ifdef ADD8_ERR_METER_MSE_EN
    check_val($sformatf("sq_sum[%0d]", i), q_v[i], ex_q[m]);
`endif
  endtask

  initial begin
    int sp1, sp2;
    for (int i = 0; i < 65536; i++) begin
      int s;
      s = (i >> 8) + (i & 255);
      if ($urandom_range(0, 3) == 0) rtab[i] = 9'($urandom_range(0, 511));
      else rtab[i] = 9'(s) ^ 9'($urandom_range(0, 3));
    end
    rtab[0] = 9'd511;
    for (int i = 0; i < 6; i++) begin
      dn[i] = -1; bc[i] = 0; arm[i] = 0; s_e[i] = 0;
    end
    for (int m = 0; m < 4; m++) model_stats(m, ex_s[m], ex_w[m], ex_c[m], ex_q[m]);

    rst_m = 1; rst_r = 1;
    start_m = 0; start_p = 0; start_z = 0; start_r = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) check_zero(i, "rst");
    rst_m = 0; rst_r = 0;
    @(posedge clk); #1;
    check_val("idle_busy", busy_v, 0);

    start_m = 1; start_p = 1; start_z = 1; start_r = 1;
    @(posedge clk); #1;
    start_m = 0; start_p = 0; start_z = 0; start_r = 0;
    for (int i = 0; i < 6; i++) begin
      s_e[i] = cyc; arm[i] = 1;
    end
    check_val("start_busy", busy_v, 6'h3F);
    check_val("start_done", done_v, 0);
    check_val("start_a", a_v[0], 0);
    check_val("start_b", b_v[0], 0);

    sp1 = $urandom_range(2000, 60000);
    sp2 = $urandom_range(2000, 60000);
    for (int j = 1; j <= 66600; j++) begin
      @(posedge clk); #1;
      start_m = (j == sp1);
      start_p = (j == sp2) || (j == 65536);
      start_z = (j == sp1) || (j == 65536);
      rst_r   = (j == 1000);
      start_r = (j == 1002);
      if (j == 1001) check_zero(5, "midrst");
      if (j == 1002) check_val("midrst_idle", busy_v[5], 0);
      if (j == 1003) begin
        s_e[5] = cyc; dn[5] = -1; bc[5] = 0;
        check_val("restart_busy[5]", busy_v[5], 1);
      end
      if (j == 65536) begin
        check_val("done_lat0", done_v[2:0], 3'b111);
        check_results(2);
      end
      if (j == 65537) begin
        check_val("done_pulse[0]", done_v[0], 0);
        check_val("redo_err_sum[2]", es_v[2], 0);
        check_val("redo_busy[2]", busy_v[2], 1);
        check_val("redo_done[2]", done_v[2], 0);
        check_val("redo_a[2]", a_v[2], 0);
        check_val("redo_b[2]", b_v[2], 0);
      end
    end

    for (int k = 0; k < 3000 && dn[5] < 0; k++) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("done_cycle[%0d]", i), dn[i], 65536 + lat_of(i));
      check_val($sformatf("busy_cycles[%0d]", i), bc[i], 65536 + lat_of(i));
      if (i != 2) check_results(i);
    end
    check_val("hold_a", a_v[0], 8'hFF);
    check_val("hold_b", b_v[0], 8'hFF);
    check_val("hold_done", done_v[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
